// File: rtl/shift_arbiter_if.sv
// Request/grant/result bundle between the two shifter requesters, the
// result consumer and the shared shifter arbiter.
interface shift_arbiter_if;
  logic        req0;
  logic [31:0] d0;
  logic [31:0] s0;
  logic        lnr0;
  logic        req1;
  logic [31:0] d1;
  logic [31:0] s1;
  logic        lnr1;
  logic        take;
  logic        gnt0;
  logic        gnt1;
  logic [31:0] y;
  logic        valid;
  logic        owner;

  // Requesters and consumer side.
  modport master (
    output req0, d0, s0, lnr0, req1, d1, s1, lnr1, take,
    input  gnt0, gnt1, y, valid, owner
  );

  // Arbiter side.
  modport slave (
    input  req0, d0, s0, lnr0, req1, d1, s1, lnr1, take,
    output gnt0, gnt1, y, valid, owner
  );
endinterface

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of one 32-bit logical barrel shifter.
// The winner's operands are registered; the shifter runs off the registers
// and the result is held until the consumer takes it.
module shift_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  shift_arbiter_if.slave bus
);

  typedef enum logic {StIdle, StFull} state_t;

  state_t      state_q;
  logic [31:0] d_q;
  logic [31:0] s_q;
  logic        lnr_q;
  logic        owner_q;
  logic        last_q;

  logic        open;
  logic        gnt0;
  logic        gnt1;
  logic [31:0] y;

  // Grant window and arbitration; grants are suppressed while in reset.
  always_comb begin
    open = (state_q == StIdle) || bus.take;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && open) begin
      if (bus.req0 && bus.req1) begin
        // Round-robin favours the requester that did not win last time.
        if (FIXED_PRIORITY || last_q) gnt0 = 1'b1;
        else                          gnt1 = 1'b1;
      end else if (bus.req0) begin
        gnt0 = 1'b1;
      end else if (bus.req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Operand capture and IDLE/FULL result-buffer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      d_q     <= '0;
      s_q     <= '0;
      lnr_q   <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else if (gnt0 || gnt1) begin
      state_q <= StFull;
      d_q     <= gnt1 ? bus.d1 : bus.d0;
      s_q     <= gnt1 ? bus.s1 : bus.s0;
      lnr_q   <= gnt1 ? bus.lnr1 : bus.lnr0;
      owner_q <= gnt1;
      last_q  <= gnt1;
    end else if (state_q == StFull && bus.take) begin
      state_q <= StIdle;
    end
  end

  // Logical shift; any amount of 32 or more flushes every bit out.
  always_comb begin
    if (|s_q[31:5]) y = '0;
    else if (lnr_q) y = d_q << s_q[4:0];
    else            y = d_q >> s_q[4:0];
  end

  assign bus.gnt0  = gnt0;
  assign bus.gnt1  = gnt1;
  assign bus.y     = y;
  assign bus.valid = (state_q == StFull);
  assign bus.owner = owner_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: a round-robin and a fixed-priority instance run
// side by side against a transaction-level model, with directed scenarios
// followed by randomized traffic.
module tb_shift_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Index 0 = round-robin instance, index 1 = fixed-priority instance.
  logic        req0_v[2], lnr0_v[2], req1_v[2], lnr1_v[2], take_v[2];
  logic [31:0] d0_v[2], s0_v[2], d1_v[2], s1_v[2];
  logic        gnt0_o[2], gnt1_o[2], valid_o[2], owner_o[2];
  logic [31:0] y_o[2];

  shift_arbiter_if bus_rr ();
  shift_arbiter_if bus_fp ();

  shift_arbiter #(.FIXED_PRIORITY(1'b0)) dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
  shift_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

  assign bus_rr.req0 = req0_v[0];
  assign bus_rr.d0   = d0_v[0];
  assign bus_rr.s0   = s0_v[0];
  assign bus_rr.lnr0 = lnr0_v[0];
  assign bus_rr.req1 = req1_v[0];
  assign bus_rr.d1   = d1_v[0];
  assign bus_rr.s1   = s1_v[0];
  assign bus_rr.lnr1 = lnr1_v[0];
  assign bus_rr.take = take_v[0];
  assign bus_fp.req0 = req0_v[1];
  assign bus_fp.d0   = d0_v[1];
  assign bus_fp.s0   = s0_v[1];
  assign bus_fp.lnr0 = lnr0_v[1];
  assign bus_fp.req1 = req1_v[1];
  assign bus_fp.d1   = d1_v[1];
  assign bus_fp.s1   = s1_v[1];
  assign bus_fp.lnr1 = lnr1_v[1];
  assign bus_fp.take = take_v[1];

  assign gnt0_o[0]  = bus_rr.gnt0;
  assign gnt1_o[0]  = bus_rr.gnt1;
  assign valid_o[0] = bus_rr.valid;
  assign owner_o[0] = bus_rr.owner;
  assign y_o[0]     = bus_rr.y;
  assign gnt0_o[1]  = bus_fp.gnt0;
  assign gnt1_o[1]  = bus_fp.gnt1;
  assign valid_o[1] = bus_fp.valid;
  assign owner_o[1] = bus_fp.owner;
  assign y_o[1]     = bus_fp.y;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", name, k, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [31:0] s,
                                            input logic l);
    if (s >= 32) return 32'h0;
    return l ? (d << s) : (d >> s);
  endfunction

  // Transaction-level model: the held result, its owner and the last winner.
  logic        m_valid[2], m_owner[2], m_last[2];
  logic [31:0] m_y[2];
  logic        gs0[2], gs1[2];
  bit          primed = 1'b0;

  always begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic e0, e1, w;
      e0 = 1'b0;
      e1 = 1'b0;
      if (!rst && (!m_valid[k] || take_v[k])) begin
        if (req0_v[k] && req1_v[k]) begin
          w  = (k == 1) ? 1'b0 : !m_last[k];
          e0 = !w;
          e1 = w;
        end else begin
          e0 = req0_v[k];
          e1 = !req0_v[k] && req1_v[k];
        end
      end
      if (primed) begin
        check("gnt0", k, 32'(gnt0_o[k]), 32'(e0));
        check("gnt1", k, 32'(gnt1_o[k]), 32'(e1));
        check("valid", k, 32'(valid_o[k]), 32'(m_valid[k]));
        check("owner", k, 32'(owner_o[k]), 32'(m_owner[k]));
        check("y", k, y_o[k], m_y[k]);
      end
      gs0[k] = gnt0_o[k];
      gs1[k] = gnt1_o[k];
      if (rst) begin
        m_valid[k] = 1'b0;
        m_owner[k] = 1'b0;
        m_last[k]  = 1'b1;
        m_y[k]     = 32'h0;
      end else if (e0) begin
        m_valid[k] = 1'b1;
        m_owner[k] = 1'b0;
        m_last[k]  = 1'b0;
        m_y[k]     = ref_shift(d0_v[k], s0_v[k], lnr0_v[k]);
      end else if (e1) begin
        m_valid[k] = 1'b1;
        m_owner[k] = 1'b1;
        m_last[k]  = 1'b1;
        m_y[k]     = ref_shift(d1_v[k], s1_v[k], lnr1_v[k]);
      end else if (m_valid[k] && take_v[k]) begin
        m_valid[k] = 1'b0;
      end
    end
    if (rst) primed = 1'b1;
  end

  task automatic set0(input logic r, input logic [31:0] d, input logic [31:0] s, input logic l);
    for (int k = 0; k < 2; k++) begin
      req0_v[k] = r; d0_v[k] = d; s0_v[k] = s; lnr0_v[k] = l;
    end
  endtask

  task automatic set1(input logic r, input logic [31:0] d, input logic [31:0] s, input logic l);
    for (int k = 0; k < 2; k++) begin
      req1_v[k] = r; d1_v[k] = d; s1_v[k] = s; lnr1_v[k] = l;
    end
  endtask

  task automatic tk(input logic t);
    for (int k = 0; k < 2; k++) take_v[k] = t;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation from requester r with a hand-computed result.
  task automatic one_op(input int r, input logic [31:0] d, input logic [31:0] s, input logic l,
                        input logic [31:0] exp);
    next_cycle();
    if (r == 0) set0(1'b1, d, s, l);
    else        set1(1'b1, d, s, l);
    tk(1'b0);
    @(negedge clk);
    check(r == 0 ? "op_gnt0" : "op_gnt1", 0, 32'(r == 0 ? gnt0_o[0] : gnt1_o[0]), 32'h1);
    next_cycle();
    if (r == 0) set0(1'b0, d, s, l);
    else        set1(1'b0, d, s, l);
    tk(1'b1);
    @(negedge clk);
    check("op_y", 0, y_o[0], exp);
    check("op_owner", 0, 32'(owner_o[0]), 32'(r));
    next_cycle();
    tk(1'b0);
  endtask

  function automatic logic [31:0] rand_shift();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 33));
  endfunction

  initial begin
    set0(1'b0, 32'h0, 32'h0, 1'b0);
    set1(1'b0, 32'h0, 32'h0, 1'b0);
    tk(1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // First operation straight out of reset.
    set0(1'b1, 32'h0000_00F0, 32'd4, 1'b1);
    @(negedge clk);
    check("first_gnt0", 0, 32'(gnt0_o[0]), 32'h1);
    next_cycle();
    set0(1'b0, 32'h0000_00F0, 32'd4, 1'b1);
    tk(1'b1);
    @(negedge clk);
    check("first_valid", 0, 32'(valid_o[0]), 32'h1);
    check("first_owner", 0, 32'(owner_o[0]), 32'h0);
    check("first_y", 0, y_o[0], 32'h0000_0F00);
    next_cycle();
    tk(1'b0);
    @(negedge clk);
    check("taken_valid", 0, 32'(valid_o[0]), 32'h0);

    // Requester 1 edge amounts.
    one_op(1, 32'h8000_0001, 32'd31, 1'b0, 32'h0000_0001);
    one_op(1, 32'h8000_0001, 32'd32, 1'b0, 32'h0000_0000);
    one_op(1, 32'h8000_0001, 32'h0001_0003, 1'b0, 32'h0000_0000);
    one_op(1, 32'h8000_0001, 32'd0, 1'b0, 32'h8000_0001);

    // Both requesting with the consumer always ready.
    next_cycle();
    set0(1'b1, 32'h0000_0003, 32'd1, 1'b1);
    set1(1'b1, 32'h0000_0003, 32'd1, 1'b0);
    tk(1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_gnt0", i, 32'(gnt0_o[0]), 32'(i % 2 == 0));
      check("rr_gnt1", i, 32'(gnt1_o[0]), 32'(i % 2 == 1));
      check("fp_gnt0", i, 32'(gnt0_o[1]), 32'h1);
      check("fp_gnt1", i, 32'(gnt1_o[1]), 32'h0);
      if (i > 0) check("rr_owner", i, 32'(owner_o[0]), 32'(i % 2 == 0));
    end
    next_cycle();
    set0(1'b0, 32'h0, 32'h0, 1'b0);
    set1(1'b0, 32'h0, 32'h0, 1'b0);
    next_cycle();
    tk(1'b0);

    // Backpressure: held result blocks requester 1 until taken.
    next_cycle();
    set0(1'b1, 32'h1234_5678, 32'd8, 1'b1);
    next_cycle();
    set0(1'b0, 32'h0, 32'h0, 1'b0);
    set1(1'b1, 32'hA5A5_0000, 32'd16, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_gnt1", i, 32'(gnt1_o[0]), 32'h0);
      check("bp_valid", i, 32'(valid_o[0]), 32'h1);
      check("bp_owner", i, 32'(owner_o[0]), 32'h0);
      check("bp_y", i, y_o[0], 32'h3456_7800);
      next_cycle();
    end
    tk(1'b1);
    @(negedge clk);
    check("bp_gnt1_take", 0, 32'(gnt1_o[0]), 32'h1);
    next_cycle();
    set1(1'b0, 32'h0, 32'h0, 1'b0);
    tk(1'b0);
    @(negedge clk);
    check("bp_new_owner", 0, 32'(owner_o[0]), 32'h1);
    check("bp_new_y", 0, y_o[0], 32'h0000_A5A5);
    next_cycle();
    tk(1'b1);
    next_cycle();
    tk(1'b0);

    // Reset while a result is pending.
    next_cycle();
    set0(1'b1, 32'h0000_000F, 32'd1, 1'b1);
    next_cycle();
    rst = 1'b1;
    set1(1'b1, 32'h0000_00FF, 32'd2, 1'b1);
    @(negedge clk);
    check("rst_valid_before", 0, 32'(valid_o[0]), 32'h1);
    check("rst_gnt0", 0, 32'(gnt0_o[0]), 32'h0);
    check("rst_gnt1", 0, 32'(gnt1_o[0]), 32'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_valid", k, 32'(valid_o[k]), 32'h0);
      check("rst_y", k, y_o[k], 32'h0);
      check("rst_owner", k, 32'(owner_o[k]), 32'h0);
      check("rst_first_gnt0", k, 32'(gnt0_o[k]), 32'h1);
    end
    next_cycle();
    set0(1'b0, 32'h0, 32'h0, 1'b0);
    set1(1'b0, 32'h0, 32'h0, 1'b0);
    tk(1'b1);
    next_cycle();
    tk(1'b0);

    // All-ones sweep in both directions.
    for (int l = 0; l < 2; l++) begin
      for (int s = 0; s < 34; s++) begin
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        one_op(0, ones, 32'(s), l[0], (l == 1) ? (ones << s) : (ones >> s));
      end
    end

    // Randomized traffic, independent per instance, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      rst = ($urandom_range(0, 149) == 0);
      for (int k = 0; k < 2; k++) begin
        if (!req0_v[k] || gs0[k] || $urandom_range(0, 19) == 0) begin
          req0_v[k] = ($urandom_range(0, 2) != 0);
          d0_v[k]   = $urandom;
          s0_v[k]   = rand_shift();
          lnr0_v[k] = 1'($urandom_range(0, 1));
        end
        if (!req1_v[k] || gs1[k] || $urandom_range(0, 19) == 0) begin
          req1_v[k] = ($urandom_range(0, 2) != 0);
          d1_v[k]   = $urandom;
          s1_v[k]   = rand_shift();
          lnr1_v[k] = 1'($urandom_range(0, 1));
        end
        take_v[k] = ($urandom_range(0, 3) != 0);
      end
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
